// File: rtl/div_restoring_8bit_if.sv
// div_restoring_8bit_if: request/result handshake bundle for the restoring divider.
interface div_restoring_8bit_if #(parameter int W = 8);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;
    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero
    );
    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/div_restoring_8bit.sv
// div_restoring_8bit: radix-2 restoring divider, one quotient bit per clock,
// valid/ready request and result ports, all outputs registered.
module div_restoring_8bit #(
    parameter int W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    div_restoring_8bit_if.slave  io
);
    localparam int CW = $clog2(W);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t        state_q, state_d;
    logic [W-1:0]  q_q, q_d, dvs_q, dvs_d, r_q, r_d;
    logic [W-1:0]  quo_q, quo_d, rem_q, rem_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ov_q, ov_d, dbz_q, dbz_d;
    logic [W:0]    sh, t;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            q_q     <= '0;
            dvs_q   <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            ov_q    <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            dvs_q   <= dvs_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            ov_q    <= ov_d;
            dbz_q   <= dbz_d;
        end
    end
    // The partial remainder always stays below the divisor, so its top bit is
    // never set and only W bits are stored; the W+1-bit subtract still sees it.
    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        dvs_d   = dvs_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        ov_d    = ov_q;
        dbz_d   = dbz_q;
        sh      = {r_q, q_q[W-1]};
        t       = sh - {1'b0, dvs_q};
        case (state_q)
            IDLE: if (io.in_valid) begin
                q_d     = io.dividend;
                dvs_d   = io.divisor;
                r_d     = '0;
                cnt_d   = '0;
                dbz_d   = 1'b0;
                state_d = (io.divisor == '0) ? DONE : RUN;
            end
            RUN: begin
                r_d   = t[W] ? sh[W-1:0] : t[W-1:0];
                q_d   = {q_q[W-2:0], ~t[W]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(W - 1)) begin
                    state_d = DONE;
                    ov_d    = 1'b1;
                    quo_d   = q_d;
                    rem_d   = r_d;
                end
            end
            // A zero divisor lands here with out_valid still low and publishes
            // its fixed result one edge after the accept.
            DONE: if (!ov_q) begin
                ov_d  = 1'b1;
                quo_d = '1;
                rem_d = q_q;
                dbz_d = 1'b1;
            end else if (io.out_ready) begin
                ov_d    = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    assign io.in_ready    = (state_q == IDLE);
    assign io.out_valid   = ov_q;
    assign io.quotient    = quo_q;
    assign io.remainder   = rem_q;
    assign io.div_by_zero = dbz_q;
endmodule

// File: tb/tb_div_restoring_8bit.sv
// tb_div_restoring_8bit: directed checks of the restoring divider with
// hand-computed results, backpressure, zero divisor and mid-run reset.
module tb_div_restoring_8bit;
    localparam int W = 8;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int tests = 0;
    int fails = 0;
    div_restoring_8bit_if #(.W(W)) io ();
    div_restoring_8bit #(.W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (io)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic chk_reset_vals(input string tag);
        chk({tag, "_in_ready"}, 32'(io.in_ready), 32'd1);
        chk({tag, "_out_valid"}, 32'(io.out_valid), 32'd0);
        chk({tag, "_quotient"}, 32'(io.quotient), 32'd0);
        chk({tag, "_remainder"}, 32'(io.remainder), 32'd0);
        chk({tag, "_dbz"}, 32'(io.div_by_zero), 32'd0);
    endtask
    task automatic run(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] eq,
                       input logic [W-1:0] er, input logic ed, input int elat,
                       input int hold, input bit early);
        int n;
        chk("in_ready_idle", 32'(io.in_ready), 32'd1);
        io.in_valid = 1'b1;
        io.dividend = a;
        io.divisor  = b;
        @(posedge clk); #1;
        io.in_valid = 1'b0;
        io.dividend = W'($urandom);
        io.divisor  = W'($urandom);
        if (early) io.out_ready = 1'b1;
        chk("in_ready_busy", 32'(io.in_ready), 32'd0);
        n = 0;
        while (!io.out_valid && n < 4 * W) begin
            @(posedge clk); #1;
            n++;
        end
        chk("latency", 32'(n), 32'(elat));
        chk("quotient", 32'(io.quotient), 32'(eq));
        chk("remainder", 32'(io.remainder), 32'(er));
        chk("dbz", 32'(io.div_by_zero), 32'(ed));
        chk("in_ready_done", 32'(io.in_ready), 32'd0);
        io.out_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("hold_valid", 32'(io.out_valid), 32'd1);
            chk("hold_quotient", 32'(io.quotient), 32'(eq));
            chk("hold_remainder", 32'(io.remainder), 32'(er));
            chk("hold_in_ready", 32'(io.in_ready), 32'd0);
        end
        io.out_ready = 1'b1;
        @(posedge clk); #1;
        io.out_ready = 1'b0;
        chk("drain_valid", 32'(io.out_valid), 32'd0);
        chk("drain_in_ready", 32'(io.in_ready), 32'd1);
    endtask
    initial begin
        logic [W-1:0] a, b;
        io.in_valid  = 1'b0;
        io.out_ready = 1'b0;
        io.dividend  = '0;
        io.divisor   = '0;
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("por");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        run(8'd200, 8'd7,   8'd28,  8'd4,  1'b0, 8, 0, 1'b0);
        run(8'd255, 8'd1,   8'd255, 8'd0,  1'b0, 8, 0, 1'b0);
        run(8'd5,   8'd9,   8'd0,   8'd5,  1'b0, 8, 0, 1'b1);
        run(8'd0,   8'd3,   8'd0,   8'd0,  1'b0, 8, 0, 1'b0);
        run(8'd255, 8'd255, 8'd1,   8'd0,  1'b0, 8, 0, 1'b0);
        run(8'd128, 8'd2,   8'd64,  8'd0,  1'b0, 8, 0, 1'b0);
        run(8'd37,  8'd0,   8'd255, 8'd37, 1'b1, 1, 0, 1'b0);
        run(8'd10,  8'd3,   8'd3,   8'd1,  1'b0, 8, 0, 1'b0);
        run(8'd50,  8'd6,   8'd8,   8'd2,  1'b0, 8, 5, 1'b0);
        io.in_valid = 1'b1;
        io.dividend = 8'd200;
        io.divisor  = 8'd7;
        @(posedge clk); #1;
        io.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1 chk_reset_vals("midrun");
        repeat (10) @(posedge clk);
        #1 chk_reset_vals("rst_held");
        rst_n = 1'b1;
        run(8'd100, 8'd10, 8'd10, 8'd0, 1'b0, 8, 0, 1'b0);
        for (int k = 0; k < 30; k++) begin
            a = W'($urandom);
            b = W'($urandom_range(0, 40));
            if (b == '0)
                run(a, b, '1, a, 1'b1, 1, $urandom_range(0, 2), 1'($urandom));
            else
                run(a, b, a / b, a % b, 1'b0, 8, $urandom_range(0, 2), 1'($urandom));
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
